// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer.
//   state_t : sequencer states (HOLD, COUNT, RUN)
//   CAUSE_* : encodings reported on the sticky CAUSE output
package reset_seq_pkg;

   typedef enum logic [1:0] {
      HOLD  = 2'd0,
      COUNT = 2'd1,
      RUN   = 2'd2
   } state_t;

   localparam logic [1:0] CAUSE_POR  = 2'b00;
   localparam logic [1:0] CAUSE_BTN  = 2'b01;
   localparam logic [1:0] CAUSE_SOFT = 2'b10;
   localparam logic [1:0] CAUSE_PLL  = 2'b11;

endpackage

// File: rtl/reset_debounce.sv
// Push-button conditioner: 2-FF synchronizer followed by a tick-based
// stability filter. OUT only moves to a new level once the synchronized
// input has been seen at that level on DEBOUNCE_TICKS consecutive ticks.
//   CLK   : system clock
//   RESET : async active-high reset, OUT and synchronizer return to INIT_LEVEL
//   TICK  : one-cycle sample strobe
//   IN    : raw asynchronous input
//   OUT   : debounced level
module reset_debounce
   import reset_seq_pkg::*;
#(
   parameter int   DEBOUNCE_TICKS = 4,
   parameter logic INIT_LEVEL     = 1'b0
) (
   input  logic CLK,
   input  logic RESET,
   input  logic TICK,
   input  logic IN,
   output logic OUT
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

   logic          sync_meta_q;
   logic          sync_q;
   logic [CW-1:0] stable_cnt_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync_meta_q  <= INIT_LEVEL;
         sync_q       <= INIT_LEVEL;
         OUT          <= INIT_LEVEL;
         stable_cnt_q <= '0;
      end else begin
         sync_meta_q <= IN;
         sync_q      <= sync_meta_q;
         if (TICK) begin
            // a tick that sees the current level again restarts the run
            if (sync_q == OUT) begin
               stable_cnt_q <= '0;
            end else if (stable_cnt_q == CW'(DEBOUNCE_TICKS - 1)) begin
               OUT          <= sync_q;
               stable_cnt_q <= '0;
            end else begin
               stable_cnt_q <= stable_cnt_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/reset_seq.sv
// Multi-channel reset sequencer. Merges power-on, debounced button, PLL
// loss of lock and CPU soft reset into one hold/release sequence and
// releases the active-low channel resets in ascending order.
//   CLK         : system clock
//   RESET       : async active-high global reset
//   SYS_RESET_N : raw push-button, active-low
//   PLL_LOCKED  : PLL lock, asynchronous
//   SOFT_RST    : one-cycle synchronous soft-reset pulse
//   RESET_N     : per-channel reset outputs, active-low, registered
//   DONE        : all channels released
//   CAUSE       : sticky cause of the last re-entry into HOLD
//
// state | meaning
// HOLD  | all channels held, counter and prescaler parked at 0
// COUNT | ticking toward channel release thresholds
// RUN   | all channels released, counter saturated
module reset_seq
   import reset_seq_pkg::*;
#(
   parameter int NUM_CH         = 3,
   parameter int PRESCALE_BITS  = 5,
   parameter int FIRST_TICKS    = 32768,
   parameter int STEP_TICKS     = 32768,
   parameter int DEBOUNCE_TICKS = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              SYS_RESET_N,
   input  logic              PLL_LOCKED,
   input  logic              SOFT_RST,
   output logic [NUM_CH-1:0] RESET_N,
   output logic              DONE,
   output logic [1:0]        CAUSE
);

   localparam int               REL_LAST = FIRST_TICKS + (NUM_CH - 1) * STEP_TICKS;
   localparam int               CNT_W    = $clog2(REL_LAST + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REL_LAST);

   state_t                   state_q, state_d;
   logic [PRESCALE_BITS-1:0] pre_q, pre_d;
   logic [PRESCALE_BITS-1:0] free_pre_q;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [NUM_CH-1:0]        rst_n_d;
   logic                     done_d;
   logic [1:0]               cause_d;
   logic                     pll_meta_q, pll_sync_q;
   logic                     tick, free_tick, dbn_tick;
   logic                     btn_level, btn_pressed, cause_any;

   assign tick      = &pre_q;
   assign free_tick = &free_pre_q;
   // the sequencer prescaler is parked in HOLD, so the debouncer needs an
   // ungated tick there to be able to see the button being released
   assign dbn_tick  = (state_q == HOLD) ? free_tick : tick;

   reset_debounce #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .INIT_LEVEL     (1'b0)
   ) u_btn_dbn (
      .CLK   (CLK),
      .RESET (RESET),
      .TICK  (dbn_tick),
      .IN    (SYS_RESET_N),
      .OUT   (btn_level)
   );

   assign btn_pressed = ~btn_level;
   assign cause_any   = btn_pressed | ~pll_sync_q | SOFT_RST;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pll_meta_q <= 1'b0;
         pll_sync_q <= 1'b0;
         free_pre_q <= '0;
      end else begin
         pll_meta_q <= PLL_LOCKED;
         pll_sync_q <= pll_meta_q;
         free_pre_q <= free_pre_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      pre_d   = pre_q + 1'b1;
      cnt_d   = cnt_q;
      rst_n_d = RESET_N;
      done_d  = DONE;
      cause_d = CAUSE;
      case (state_q)
         HOLD: begin
            pre_d   = '0;
            cnt_d   = '0;
            rst_n_d = '0;
            done_d  = 1'b0;
            if (!cause_any) state_d = COUNT;
         end
         COUNT: begin
            if (tick && (cnt_q != CNT_LAST)) cnt_d = cnt_q + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
               rst_n_d[i] = (cnt_q >= CNT_W'(FIRST_TICKS + i * STEP_TICKS));
            end
            if (cnt_q == CNT_LAST) begin
               state_d = RUN;
               done_d  = 1'b1;
            end
         end
         RUN: begin
            rst_n_d = '1;
            done_d  = 1'b1;
         end
         default: state_d = HOLD;
      endcase
      // abort has priority over everything above; a partial release restarts
      if ((state_q != HOLD) && cause_any) begin
         state_d = HOLD;
         pre_d   = '0;
         cnt_d   = '0;
         rst_n_d = '0;
         done_d  = 1'b0;
         if (!pll_sync_q)     cause_d = CAUSE_PLL;
         else if (btn_pressed) cause_d = CAUSE_BTN;
         else                  cause_d = CAUSE_SOFT;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= HOLD;
         pre_q   <= '0;
         cnt_q   <= '0;
         RESET_N <= '0;
         DONE    <= 1'b0;
         CAUSE   <= CAUSE_POR;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cnt_q   <= cnt_d;
         RESET_N <= rst_n_d;
         DONE    <= done_d;
         CAUSE   <= cause_d;
      end
   end

endmodule
